// File: rtl/store_merge_if.sv
// Store request / data RAM bundle for store_merge_unit.
// The master side is the requester plus RAM; the slave side is the unit.
interface store_merge_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_merge_unit.sv
// SB/SH/SW store unit: sub-word stores do read-modify-write on a word RAM,
// aligned full-word stores skip the read, misaligned SH/SW report err.
module store_merge_unit #(
    parameter logic [31:0] BASE       = 32'h1001_0000,
    parameter int          ADDR_W     = 10,
    parameter int          RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    store_merge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, ERR} state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0] diff;
    logic [1:0]  req_off;
    logic        accept;
    logic [31:0] merged;

    // Wrapping subtraction: addresses below BASE simply alias into the RAM.
    assign diff    = bus.req_addr - BASE;
    assign req_off = diff[1:0];
    assign accept  = bus.req_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            size_q  <= size_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_size[1])
                        state_d = (req_off == 2'd0) ? WR : ERR;
                    else if (bus.req_size[0] && req_off[0])
                        state_d = ERR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = WAIT;
            WAIT:    if (cnt_q == 3'd0) state_d = WR;
            WR:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read word with the latched byte/half dropped into its lanes.
    always_comb begin
        merged = bus.mem_rdata;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = data_q[15:0];
        end else begin
            merged[15:0] = data_q[15:0];
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        off_d   = off_q;
        size_d  = size_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_d  = (state_q == WR) || (state_q == ERR);
        err_d   = (state_q == ERR);
        if (accept) begin
            off_d  = req_off;
            size_d = bus.req_size;
            data_d = bus.req_data;
            addr_d = diff[ADDR_W+1:2];
            case (bus.req_size)
                2'b00:   be_d = 4'b0001 << req_off;
                2'b01:   be_d = req_off[1] ? 4'b1100 : 4'b0011;
                default: be_d = 4'b1111;
            endcase
            if (bus.req_size[1]) wdata_d = bus.req_data;
        end
        if (state_q == RD) cnt_d = CNT_INIT;
        if (state_q == WAIT) begin
            if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            else               wdata_d = merged;
        end
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.mem_rd_en = (state_q == RD);
        bus.mem_wr_en = (state_q == WR);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_be    = be_q;
        bus.done      = done_q;
        bus.err       = err_q;
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: two instances (read latency 1 and 3), each with
// its own RAM model, checked against directed tables and a byte-level model.
module tb_store_merge_unit;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic        rv[2];
    logic [31:0] ra[2];
    logic [31:0] rdt[2];
    logic [1:0]  rs[2];
    logic        rdy[2], dn[2], er[2], rde[2], wre[2];
    logic [9:0]  ma[2];
    logic [31:0] wd[2];
    logic [3:0]  be[2];
    logic        pl_we[2];
    logic [9:0]  pl_a[2];
    logic [31:0] pl_d[2];
    logic [9:0]  peek_a[2];
    logic [31:0] peek[2];

    logic [31:0] shadow[2][1024];
    int lat_of[2] = '{1, 3};

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int LAT = (g == 0) ? 1 : 3;
        store_merge_if #(.ADDR_W(10)) bus();
        store_merge_unit #(.BASE(BASE), .ADDR_W(10), .RD_LATENCY(LAT)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
        assign bus.req_valid = rv[g];
        assign bus.req_addr  = ra[g];
        assign bus.req_data  = rdt[g];
        assign bus.req_size  = rs[g];
        assign rdy[g] = bus.req_ready;
        assign dn[g]  = bus.done;
        assign er[g]  = bus.err;
        assign rde[g] = bus.mem_rd_en;
        assign wre[g] = bus.mem_wr_en;
        assign ma[g]  = bus.mem_addr;
        assign wd[g]  = bus.mem_wdata;
        assign be[g]  = bus.mem_be;

        logic [31:0] mem [1024];
        logic [31:0] pipe [LAT];
        always @(posedge clk) begin
            if (pl_we[g]) mem[pl_a[g]] <= pl_d[g];
            else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
            pipe[0] <= bus.mem_rd_en ? mem[bus.mem_addr] : 32'hDEAD_DEAD;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.mem_rdata = pipe[LAT-1];
        assign peek[g] = mem[peek_a[g]];
    end

    typedef struct {
        logic       err;
        int         lat;
        int         nrd;
        int         nwr;
        logic [9:0] raddr;
        logic [9:0] waddr;
        logic [31:0] wdata;
        logic [3:0] be;
    } res_t;

    typedef struct {
        logic [31:0] pre;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic preload(input int u, input logic [9:0] i, input logic [31:0] v);
        pl_we[u] = 1'b1; pl_a[u] = i; pl_d[u] = v;
        @(negedge clk);
        pl_we[u] = 1'b0;
        shadow[u][i] = v;
    endtask

    task automatic read_ram(input int u, input logic [9:0] i, output logic [31:0] v);
        peek_a[u] = i;
        #1;
        v = peek[u];
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_store(input int u, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, output res_t r);
        chk("req_ready_before_accept", 32'(rdy[u]), 32'd1);
        rv[u] = 1'b1; ra[u] = a; rdt[u] = d; rs[u] = s;
        r = '{err: 1'b0, lat: -1, nrd: 0, nwr: 0, raddr: '0, waddr: '0, wdata: '0, be: '0};
        @(posedge clk);
        #1 rv[u] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rde[u]) begin r.nrd++; r.raddr = ma[u]; end
            if (wre[u]) begin r.nwr++; r.waddr = ma[u]; r.wdata = wd[u]; r.be = be[u]; end
            if (dn[u]) begin r.lat = k; r.err = er[u]; break; end
        end
        if (r.lat < 0) begin
            checks++; errors++;
            $display("FAIL timeout u%0d: no done within 40 cycles, want done", u);
        end
    endtask

    // Byte-level reference: a store writes 1/2/4 bytes starting at lane off
    // and is legal only if off is a multiple of its size.
    task automatic model_check(input int u, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s, input res_t r);
        logic [31:0] diff, word, got;
        logic [1:0]  off;
        logic [9:0]  idx;
        logic [3:0]  bem;
        int n, e_lat;
        diff = a - BASE;
        off  = diff[1:0];
        idx  = diff[11:2];
        n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        if ((int'(off) % n) != 0) begin
            chk("m_lat_err", 32'(r.lat), 32'd2);
            chk("m_err", 32'(r.err), 32'd1);
            chk("m_nrd_err", 32'(r.nrd), 32'd0);
            chk("m_nwr_err", 32'(r.nwr), 32'd0);
        end else begin
            word = shadow[u][idx];
            bem  = 4'b0000;
            for (int i = 0; i < n; i++) begin
                word[8*(int'(off)+i) +: 8] = d[8*i +: 8];
                bem[int'(off)+i] = 1'b1;
            end
            e_lat = (n == 4) ? 2 : 3 + lat_of[u];
            chk("m_lat", 32'(r.lat), 32'(e_lat));
            chk("m_err0", 32'(r.err), 32'd0);
            chk("m_nrd", 32'(r.nrd), (n < 4) ? 32'd1 : 32'd0);
            chk("m_nwr", 32'(r.nwr), 32'd1);
            if (n < 4) chk("m_raddr", 32'(r.raddr), 32'(idx));
            chk("m_waddr", 32'(r.waddr), 32'(idx));
            chk("m_wdata", r.wdata, word);
            chk("m_be", 32'(r.be), 32'(bem));
            shadow[u][idx] = word;
            read_ram(u, idx, got);
            chk("m_ram", got, word);
        end
    endtask

    initial begin
        vec_t        tbl[8];
        res_t        r;
        logic [31:0] a, d, got, diff;
        logic [1:0]  s;
        int          off, nw;

        tbl[0] = '{32'hAABBCCDD, 32'h1001_0006, 32'h1234_5677, 2'd0, 32'hAA77CCDD, 4'b0100, 1'b0, 4};
        tbl[1] = '{32'hAABBCCDD, 32'h1001_0006, 32'hFFFF_BEEF, 2'd1, 32'hBEEFCCDD, 4'b1100, 1'b0, 4};
        tbl[2] = '{32'hAABBCCDD, 32'h1001_0004, 32'hFFFF_BEEF, 2'd1, 32'hAABBBEEF, 4'b0011, 1'b0, 4};
        tbl[3] = '{32'h0BADF00D, 32'h1001_0008, 32'hDEAD_BEEF, 2'd2, 32'hDEADBEEF, 4'b1111, 1'b0, 2};
        tbl[4] = '{32'hAABBCCDD, 32'h1001_0003, 32'h0000_1234, 2'd1, 32'h0,        4'b0000, 1'b1, 2};
        tbl[5] = '{32'hAABBCCDD, 32'h1001_0002, 32'h0000_1234, 2'd2, 32'h0,        4'b0000, 1'b1, 2};
        tbl[6] = '{32'hAABBCCDD, 32'h1001_0004, 32'h0000_0099, 2'd0, 32'hAABBCC99, 4'b0001, 1'b0, 4};
        tbl[7] = '{32'h55555555, 32'h1001_000C, 32'h0102_0304, 2'd3, 32'h01020304, 4'b1111, 1'b0, 2};

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            rv[u] = 1'b0; ra[u] = '0; rdt[u] = '0; rs[u] = '0;
            pl_we[u] = 1'b0; pl_a[u] = '0; pl_d[u] = '0; peek_a[u] = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", 32'(rdy[u]), 32'd1);
            chk("rst_done", 32'(dn[u]), 32'd0);
            chk("rst_err", 32'(er[u]), 32'd0);
            chk("rst_rd_en", 32'(rde[u]), 32'd0);
            chk("rst_wr_en", 32'(wre[u]), 32'd0);
            chk("rst_outs", {wd[u][31:14] | 18'(ma[u]), wd[u][13:0] | 14'(be[u])}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 16; i++) begin
                preload(u, 10'(i), $urandom);
                preload(u, 10'(1008 + i), $urandom);
            end

        // Directed table on the latency-1 instance.
        for (int t = 0; t < 8; t++) begin
            diff = tbl[t].a - BASE;
            preload(0, diff[11:2], tbl[t].pre);
            do_store(0, tbl[t].a, tbl[t].d, tbl[t].s, r);
            chk($sformatf("t%0d_lat", t), 32'(r.lat), 32'(tbl[t].lat));
            chk($sformatf("t%0d_err", t), 32'(r.err), 32'(tbl[t].err));
            if (tbl[t].err) begin
                chk($sformatf("t%0d_no_strobes", t), 32'(r.nrd + r.nwr), 32'd0);
            end else begin
                chk($sformatf("t%0d_wdata", t), r.wdata, tbl[t].wdata);
                chk($sformatf("t%0d_be", t), 32'(r.be), 32'(tbl[t].be));
                chk($sformatf("t%0d_waddr", t), 32'(r.waddr), 32'(diff[11:2]));
            end
            model_check(0, tbl[t].a, tbl[t].d, tbl[t].s, r);
        end

        // Back-to-back SBs on the latency-3 instance; second accepted in done cycle.
        preload(1, 10'd0, 32'h0000_0000);
        do_store(1, BASE, 32'h0000_0011, 2'd0, r);
        chk("b2b_first_lat", 32'(r.lat), 32'd6);
        model_check(1, BASE, 32'h0000_0011, 2'd0, r);
        do_store(1, BASE + 32'd3, 32'h0000_0044, 2'd0, r);
        chk("b2b_second_lat", 32'(r.lat), 32'd6);
        model_check(1, BASE + 32'd3, 32'h0000_0044, 2'd0, r);
        read_ram(1, 10'd0, got);
        chk("b2b_final_word", got, 32'h4400_0011);

        // Reset while waiting on read data abandons the store.
        @(negedge clk);
        preload(0, 10'd5, 32'h5566_7788);
        rv[0] = 1'b1; ra[0] = BASE + 32'd21; rdt[0] = 32'h0000_00A5; rs[0] = 2'd0;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        chk("rstw_rd_strobe", 32'(rde[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_ready", 32'(rdy[0]), 32'd1);
        chk("rstw_done", 32'(dn[0]), 32'd0);
        chk("rstw_wr_en", 32'(wre[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nw = 0;
        repeat (6) begin
            @(negedge clk);
            if (wre[0]) nw++;
        end
        chk("rstw_no_write", 32'(nw), 32'd0);
        read_ram(0, 10'd5, got);
        chk("rstw_ram_kept", got, 32'h5566_7788);
        do_store(0, BASE + 32'd21, 32'h0000_00A5, 2'd0, r);
        model_check(0, BASE + 32'd21, 32'h0000_00A5, 2'd0, r);

        // Random stores on both instances, including addresses below BASE.
        for (int u = 0; u < 2; u++)
            for (int it = 0; it < 60; it++) begin
                s   = 2'($urandom_range(0, 3));
                off = int'($urandom_range(0, 3));
                if ($urandom_range(0, 2) != 0) begin
                    if (s == 2'd1) off = off & 2;
                    else if (s[1]) off = 0;
                end
                if ($urandom_range(0, 7) == 0)
                    a = BASE - 32'(4 * $urandom_range(1, 16)) + 32'(off);
                else
                    a = BASE + 32'(4 * $urandom_range(0, 15) + off);
                d = $urandom;
                do_store(u, a, d, s, r);
                model_check(u, a, d, s, r);
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Write-side counterpart of the load byte/half extractor.
- Executes SB/SH/SW from the memory stage into a word-wide data RAM that has no byte-enables honoured on the read path.
- Sub-word stores use a read-modify-write: read the word, merge the byte or half at the offset, write the word back.
- Full-word stores bypass the read.

Parameters:
- BASE, 32'h10010000, data-segment base; byte offset = req_addr - BASE.
- ADDR_W, 10, RAM word-index width.
- RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rdata; legal values 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request.
- req_ready  out  1  unit idle, request accepted when req_valid&req_ready.
- req_addr  in  32  byte address.
- req_data  in  32  store source register; byte = [7:0], half = [15:0].
- req_size  in  2  2'b00 SB, 2'b01 SH, 2'b10 SW, 2'b11 reserved (treated as SW).
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned SH/SW, nothing written.
- mem_addr  out  ADDR_W  word index = (req_addr-BASE)[ADDR_W+1:2], registered at accept.
- mem_rd_en  out  1  read strobe.
- mem_rdata  in  32  RAM read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  32  merged word.
- mem_be  out  4  informational lane mask of the written bytes.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - State goes to IDLE and cnt to 0.
  - All outputs go to 0 except req_ready=1.
  - Internal registers clear.
  - Reset mid-operation abandons the store: no write is issued, and a late mem_rdata is ignored.
- Accept: in IDLE with req_valid=1.
  - Latch off=(req_addr-BASE)[1:0], word index, data and size.
  - req_ready=1 only in IDLE.
- States:
  - IDLE -> WR if SW and off==0.
  - IDLE -> ERR if (SH and off[0]) or (SW and off!=0).
  - IDLE -> RD otherwise.
  - RD: mem_rd_en=1 for exactly one cycle; cnt<=RD_LATENCY-1; -> WAIT.
  - WAIT: if cnt==0, capture mem_rdata into rbuf and go -> WR; else cnt<=cnt-1.
  - WR: mem_wr_en=1 for one cycle; mem_wdata, mem_be and mem_addr are stable; -> IDLE.
  - ERR: -> IDLE. No mem strobes.
- done: registered pulse in the cycle after WR or ERR, i.e. the first IDLE cycle.
  - err=1 alongside done only when leaving ERR.
  - A new request may be accepted in the same cycle done is high.
- Merge rules (lane k = bits [8k+7:8k]):
  - SB: lane off <- data[7:0]; other lanes from rbuf; be = 1<<off.
  - SH: off[1]=0 -> [15:0] <- data[15:0], be=4'b0011; off[1]=1 -> [31:16] <- data[15:0], be=4'b1100.
  - SW: wdata=data, be=4'b1111, mem_rdata is not used.
- Latency, accept cycle = 0:
  - SB/SH: done at cycle 3+RD_LATENCY.
  - SW: done at cycle 2.
  - ERR: done at cycle 2.
- Outputs with no strobe active hold their last values; the bench checks them only under the strobes.
- Address arithmetic: 32-bit subtraction wraps. Addresses below BASE are not range-checked; the low ADDR_W+2 bits of the difference are used.

Test Plan:
- SB merge: RAM[1]=0xAABBCCDD; SB addr 0x10010006 data 0x12345677 -> one mem_rd_en with mem_addr=1, then mem_wr_en with wdata 0xAA77CCDD, be 4'b0100; done at cycle 4 (RD_LATENCY=1); err=0.
- SH upper half: RAM[1]=0xAABBCCDD; SH addr 0x10010006 data 0xFFFFBEEF -> wdata 0xBEEFCCDD, be 4'b1100. SH addr 0x10010004 -> 0xAABBBEEF, be 4'b0011.
- SW bypass: SW addr 0x10010008 data 0xDEADBEEF -> no mem_rd_en; mem_wr_en at cycle 1 with mem_addr=2, wdata 0xDEADBEEF, be 4'b1111; done at cycle 2.
- Misaligned: SH addr 0x10010003 -> no strobes, done=1 and err=1 at cycle 2. SW addr 0x10010002 -> same response.
- RD_LATENCY=3, back-to-back: two SBs to lanes 0 and 3 of RAM[0]=0x00000000 with data 0x11 and 0x44, the second request accepted in the done cycle of the first -> final RAM[0]=0x44000011; each done at cycle 6 after its accept.
- Reset in WAIT: assert rst_n=0 one cycle after mem_rd_en -> no mem_wr_en; RAM unchanged; req_ready=1 and done=0 immediately. A subsequent SB completes normally.
